load_align_unit: RTL and testbench

- Parametrised successor to the load-data byte control in the MEM stage.
- Accepts a load request (address, size, signedness) and issues one or two lane-aligned memory reads.
- Extracts the addressed bytes, shifts them to bit 0, then zero- or sign-extends them.
- Supports misaligned loads that cross a lane boundary, plus optional misalignment trapping for the exception path.

---
 rtl/load_align_unit.sv | 143 ++++++++++++++
 tb/tb_load_align_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two lane-aligned reads for a byte/half/word/dword load,
// then shifts the addressed bytes down to bit 0 and zero- or sign-extends them.
module load_align_unit #(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned LOG_L = $clog2(LANES);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StDone, StErr} state_e;

  state_e state_q, state_d;

  logic              accept;
  logic [31:0]       off_in, nb_in;
  logic              illegal_in, cross_in, err_in;
  logic [ADDR_W-1:0] base_in;

  logic [LOG_L-1:0]  off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              cross_q;
  logic [DATA_W-1:0] beat0_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [2*DATA_W-1:0] pair, shifted;
  logic [31:0]         nbits;
  logic [DATA_W-1:0]   keep, result;
  logic                sgn;

  // Request classification, evaluated on the raw request fields at accept time.
  always_comb begin
    off_in     = 32'(req_addr_i[LOG_L-1:0]);
    nb_in      = 32'd1 << req_size_i;
    illegal_in = nb_in > LANES;
    cross_in   = (off_in + nb_in) > LANES;
    err_in     = illegal_in || (cross_in && !ALLOW_MISALIGNED);
    base_in    = {req_addr_i[ADDR_W-1:LOG_L], {LOG_L{1'b0}}};
  end

  assign accept = req_valid_i && req_ready_o;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = err_in ? StErr : StRd0;
      end
      StRd0:  state_d = cross_q ? StRd1 : StDone;
      StRd1:  state_d = StDone;
      StDone: state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready_o = 1'b0;
    mem_rd_en_o = 1'b0;
    unique case (state_q)
      StIdle:       req_ready_o = !rst_i;
      StRd0, StRd1: mem_rd_en_o = 1'b1;
      default:      ;
    endcase
  end

  // In DONE the final beat is still on mem_rdata_i; beat0 was captured during RD1 for crossers.
  always_comb begin
    pair    = cross_q ? {mem_rdata_i, beat0_q} : {{DATA_W{1'b0}}, mem_rdata_i};
    shifted = pair >> {off_q, 3'b000};
    nbits   = 32'd8 << size_q;
    keep    = ~({DATA_W{1'b1}} << nbits);
    sgn     = 1'b0;
    for (int unsigned i = 0; i < 2 * DATA_W; i++) begin
      if (i == nbits - 32'd1) sgn = shifted[i];
    end
    sgn    = sgn && signed_q;
    result = (shifted[DATA_W-1:0] & keep) | ({DATA_W{sgn}} & ~keep);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q       <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      cross_q     <= 1'b0;
      beat0_q     <= '0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        off_q    <= req_addr_i[LOG_L-1:0];
        size_q   <= req_size_i;
        signed_q <= req_signed_i;
        cross_q  <= cross_in;
        if (!err_in) mem_addr_q <= base_in;
      end
      if (state_q == StRd0 && cross_q) mem_addr_q <= mem_addr_q + ADDR_W'(LANES);
      if (state_q == StRd1) beat0_q <= mem_rdata_i;
      rsp_valid_q <= (state_q == StDone) || (state_q == StErr);
      rsp_err_q   <= state_q == StErr;
      if (state_q == StDone) rsp_data_q <= result;
      if (state_q == StErr)  rsp_data_q <= '0;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three instances (32-bit split, 32-bit trapping, 64-bit)
// driven from a vector table plus hand sequences for back-to-back and mid-op reset.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;

  logic        rdy0, rdy1, rdy2, rd0, rd1, rd2, vld0, vld1, vld2, err0, err1, err2;
  logic [31:0] ma0, ma1, ma2, rdat0, rdat1, rsp0, rsp1;
  logic [63:0] rdat2, rsp2;

  logic [31:0] mem32 [logic [31:0]];
  logic [63:0] mem64 [logic [31:0]];

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 0), .req_ready_o(rdy0),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
    .mem_rd_en_o(rd0), .mem_addr_o(ma0), .mem_rdata_i(rdat0),
    .rsp_valid_o(vld0), .rsp_data_o(rsp0), .rsp_err_o(err0)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_nm (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 1), .req_ready_o(rdy1),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
    .mem_rd_en_o(rd1), .mem_addr_o(ma1), .mem_rdata_i(rdat1),
    .rsp_valid_o(vld1), .rsp_data_o(rsp1), .rsp_err_o(err1)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 2), .req_ready_o(rdy2),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
    .mem_rd_en_o(rd2), .mem_addr_o(ma2), .mem_rdata_i(rdat2),
    .rsp_valid_o(vld2), .rsp_data_o(rsp2), .rsp_err_o(err2)
  );

  function automatic logic [31:0] rd32(logic [31:0] a);
    return mem32.exists(a) ? mem32[a] : 32'h0;
  endfunction

  function automatic logic [63:0] rd64(logic [31:0] a);
    return mem64.exists(a) ? mem64[a] : 64'h0;
  endfunction

  // One-cycle read latency memories
  always @(posedge clk) begin
    if (rd0) rdat0 <= rd32(ma0);
    if (rd1) rdat1 <= rd32(ma1);
    if (rd2) rdat2 <= rd64(ma2);
  end

  logic        m_rdy, m_rd, m_vld, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  always_comb begin
    m_rdy = rdy0; m_rd = rd0; m_vld = vld0; m_err = err0; m_addr = ma0; m_data = {32'h0, rsp0};
    if (sel == 1) begin
      m_rdy = rdy1; m_rd = rd1; m_vld = vld1; m_err = err1; m_addr = ma1; m_data = {32'h0, rsp1};
    end else if (sel == 2) begin
      m_rdy = rdy2; m_rd = rd2; m_vld = vld2; m_err = err2; m_addr = ma2; m_data = rsp2;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] lo, hi, exp;
    logic        err;
    int          lat, nrd;
    logic [31:0] a0, a1;
  } vec_t;

  function automatic vec_t mk(int s, logic [31:0] addr, logic [1:0] size, logic sgn,
                              logic [63:0] lo, logic [63:0] hi, logic [63:0] exp, logic err,
                              int lat, int nrd, logic [31:0] a0, logic [31:0] a1);
    vec_t v;
    v.sel = s; v.addr = addr; v.size = size; v.sgn = sgn; v.lo = lo; v.hi = hi; v.exp = exp;
    v.err = err; v.lat = lat; v.nrd = nrd; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int lat = 0, nrd = 0;
    logic [31:0] a0 = '0, a1 = '0, base;
    logic [63:0] d = '0;
    logic e = 1'b0;
    base = (v.sel == 2) ? {v.addr[31:3], 3'b0} : {v.addr[31:2], 2'b0};
    if (v.sel == 2) begin
      mem64[base] = v.lo; mem64[base + 32'd8] = v.hi;
    end else begin
      mem32[base] = v.lo[31:0]; mem32[base + 32'd4] = v.hi[31:0];
    end
    @(negedge clk);
    sel = v.sel; req_addr = v.addr; req_size = v.size; req_signed = v.sgn; req_valid = 1'b1;
    #1 chk($sformatf("v%0d.ready", id), 64'(m_rdy), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_rd) begin
        if (nrd == 0) a0 = m_addr; else a1 = m_addr;
        nrd++;
      end
      if (m_vld) begin
        lat = k; d = m_data; e = m_err;
        break;
      end
    end
    chk($sformatf("v%0d.lat", id), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d.data", id), d, v.exp);
    chk($sformatf("v%0d.err", id), 64'(e), 64'(v.err));
    chk($sformatf("v%0d.nrd", id), 64'(nrd), 64'(v.nrd));
    if (v.nrd > 0) chk($sformatf("v%0d.addr0", id), 64'(a0), 64'(v.a0));
    if (v.nrd > 1) chk($sformatf("v%0d.addr1", id), 64'(a1), 64'(v.a1));
  endtask

  vec_t vecs[16];
  int seen, k3;

  initial begin
    vecs[0]  = mk(0, 32'h100, 2, 0, 64'h8899AABB, 64'h0, 64'h8899AABB, 0, 3, 1, 32'h100, 0);
    vecs[1]  = mk(0, 32'h103, 0, 1, 64'h80FF1234, 64'h0, 64'hFFFFFF80, 0, 3, 1, 32'h100, 0);
    vecs[2]  = mk(0, 32'h103, 0, 0, 64'h80FF1234, 64'h0, 64'h00000080, 0, 3, 1, 32'h100, 0);
    vecs[3]  = mk(0, 32'h101, 1, 0, 64'h11223344, 64'h0, 64'h00002233, 0, 3, 1, 32'h100, 0);
    vecs[4]  = mk(0, 32'h0FE, 2, 0, 64'hAABBCCDD, 64'h11223344, 64'h3344AABB, 0, 4, 2,
                  32'h0FC, 32'h100);
    vecs[5]  = mk(0, 32'h0FF, 1, 1, 64'hAABBCCDD, 64'h11223344, 64'h000044AA, 0, 4, 2,
                  32'h0FC, 32'h100);
    vecs[6]  = mk(0, 32'h102, 1, 1, 64'h80FF1234, 64'h0, 64'hFFFF80FF, 0, 3, 1, 32'h100, 0);
    vecs[7]  = mk(0, 32'h100, 2, 1, 64'h8899AABB, 64'h0, 64'h8899AABB, 0, 3, 1, 32'h100, 0);
    vecs[8]  = mk(0, 32'hFFFFFFFE, 2, 0, 64'hAABBCCDD, 64'h11223344, 64'h3344AABB, 0, 4, 2,
                  32'hFFFFFFFC, 32'h0);
    vecs[9]  = mk(0, 32'h100, 3, 0, 64'h8899AABB, 64'h0, 64'h0, 1, 2, 0, 0, 0);
    vecs[10] = mk(1, 32'h0FE, 2, 0, 64'hAABBCCDD, 64'h11223344, 64'h0, 1, 2, 0, 0, 0);
    vecs[11] = mk(1, 32'h101, 1, 0, 64'h11223344, 64'h0, 64'h00002233, 0, 3, 1, 32'h100, 0);
    vecs[12] = mk(1, 32'h100, 3, 0, 64'h11223344, 64'h0, 64'h0, 1, 2, 0, 0, 0);
    vecs[13] = mk(2, 32'h106, 2, 1, 64'h8877665544332211, 64'h0123456789ABCDEF,
                  64'hFFFFFFFFCDEF8877, 0, 4, 2, 32'h100, 32'h108);
    vecs[14] = mk(2, 32'h106, 2, 0, 64'h8877665544332211, 64'h0123456789ABCDEF,
                  64'h00000000CDEF8877, 0, 4, 2, 32'h100, 32'h108);
    vecs[15] = mk(2, 32'h108, 3, 1, 64'hF123456789ABCDEF, 64'h0, 64'hF123456789ABCDEF, 0, 3, 1,
                  32'h108, 0);

    // Reset state
    @(negedge clk);
    chk("rst.ready", 64'(rdy0), 64'd0);
    chk("rst.rd_en", 64'(rd0), 64'd0);
    chk("rst.rsp", {rsp0, 31'd0, vld0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back: second request accepted in the response cycle of the first
    mem32[32'h100] = 32'h8899AABB;
    mem32[32'h104] = 32'h01020304;
    @(negedge clk);
    sel = 0; req_addr = 32'h100; req_size = 2; req_signed = 0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b.vld1", 64'(vld0), 64'd1);
    chk("b2b.data1", 64'(rsp0), 64'h8899AABB);
    chk("b2b.ready", 64'(rdy0), 64'd1);
    req_addr = 32'h104; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (vld0) begin k3 = k; break; end
    end
    chk("b2b.lat2", 64'(k3), 64'd3);
    chk("b2b.data2", 64'(rsp0), 64'h01020304);

    // Reset asserted while the second beat of a crossing load is being read
    mem32[32'h0FC] = 32'hAABBCCDD;
    mem32[32'h100] = 32'h11223344;
    @(negedge clk);
    req_addr = 32'h0FE; req_size = 2; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.rd1_en", 64'(rd0), 64'd1);
    chk("mid.rd1_addr", 64'(ma0), 64'h100);
    rst = 1'b1;
    #1;
    chk("mid.rst_rd", {31'd0, rd0, ma0}, 64'd0);
    chk("mid.rst_rsp", {rsp0, 30'd0, vld0, err0}, 64'd0);
    chk("mid.rst_rdy", 64'(rdy0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (vld0) seen++;
    end
    chk("mid.norsp", 64'(seen), 64'd0);
    run_vec(vecs[0], 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
